// File: rtl/mem_arbiter_m_pkg.sv
// Shared definitions for the RAM-port arbiter: FSM encodings, RAM window
// decode bit and a small width helper.
// Optional feature macro used by the arbiter files: MEM_ARB_LOCK_EN.
package mem_arbiter_m_pkg;

    localparam logic [1:0] MEM_ARB_IDLE   = 2'd0;
    localparam logic [1:0] MEM_ARB_ACCESS = 2'd1;
    localparam logic [1:0] MEM_ARB_DONE   = 2'd2;

    // Address bit that selects the RAM window (0 = inside the RAM)
    localparam int MEM_ARB_RAM_WINDOW_BIT = 15;

    // Width of the physical RAM address bus
    localparam int MEM_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = MEM_ARB_IDLE,
        ST_ACCESS = MEM_ARB_ACCESS,
        ST_DONE   = MEM_ARB_DONE
    } arb_state_t;

    // Bits needed to hold a requester index (at least one)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_m_if.sv
// Requester/RAM bus bundle for the arbiter. The slave modport is the arbiter
// side; the master modport is the requesters plus the RAM.
// req_lock exists only when MEM_ARB_LOCK_EN is defined.
interface mem_arbiter_m_if
    import mem_arbiter_m_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_we;
`ifdef MEM_ARB_LOCK_EN
    logic [NUM_REQ-1:0]            req_lock;
`endif
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            ack;
    logic                          err;
    logic [DATA_WIDTH-1:0]         rdata;
    logic [NUM_REQ-1:0]            grant;
    logic [MEM_ADDR_W-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0]         mem_wdata;
    logic [DATA_WIDTH-1:0]         mem_rdata;
    logic                          mem_cs;
    logic                          mem_oe;
    logic                          mem_we;

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
`ifdef MEM_ARB_LOCK_EN
        input  req_lock,
`endif
        output ack, err, rdata, grant, mem_addr, mem_wdata, mem_cs, mem_oe, mem_we
    );

    modport master (
        output req, req_we, req_addr, req_wdata, mem_rdata,
`ifdef MEM_ARB_LOCK_EN
        output req_lock,
`endif
        input  ack, err, rdata, grant, mem_addr, mem_wdata, mem_cs, mem_oe, mem_we
    );

endinterface

// File: rtl/mem_arbiter_m_rr_picker.sv
// Combinational round-robin picker: searches from last+1 (wrapping) and
// returns the first requester that is asking, one-hot and as an index.
module rr_picker_m
    import mem_arbiter_m_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_idx,
    output logic               o_valid
);

    // First requesting slot in rotated order wins
    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!o_valid && i_req[i] && (i == (int'(i_last) + k) % NUM_REQ)) begin
                    o_valid    = 1'b1;
                    o_grant[i] = 1'b1;
                    o_idx      = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_m.sv
// Round-robin arbiter sharing one RAM port between NUM_REQ masters.
// IDLE -> ACCESS (one strobe cycle) -> DONE (ack) -> IDLE; all outputs registered.
// MEM_ARB_LOCK_EN: req_lock held in DONE keeps priority with the current owner.
module mem_arbiter_m
    import mem_arbiter_m_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input logic            clk,
    input logic            reset,
    mem_arbiter_m_if.slave bus
);

    localparam int IW = idx_width(NUM_REQ);

    arb_state_t              r_state, w_state_nxt;
    logic [IW-1:0]           r_last, w_last_nxt;
    logic                    r_we, w_we_nxt;
    logic                    r_oow, w_oow_nxt;
    logic [NUM_REQ-1:0]      r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0]      r_ack, w_ack_nxt;
    logic                    r_err, w_err_nxt;
    logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_nxt;
    logic [MEM_ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic                    r_cs, w_cs_nxt;
    logic                    r_oe, w_oe_nxt;
    logic                    r_mwe, w_mwe_nxt;

    logic [NUM_REQ-1:0]      w_pick;
    logic [IW-1:0]           w_pick_idx;
    logic                    w_pick_valid;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;
    logic                    w_sel_we;

    rr_picker_m #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
        .i_req   (bus.req),
        .i_last  (r_last),
        .o_grant (w_pick),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Route the winning requester's address, data and direction
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_we    = bus.req_we[i];
            end
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_we_nxt        = r_we;
        w_oow_nxt       = r_oow;
        w_grant_nxt     = r_grant;
        w_ack_nxt       = '0;
        w_err_nxt       = 1'b0;
        w_rdata_nxt     = r_rdata;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_cs_nxt        = 1'b0;
        w_oe_nxt        = 1'b0;
        w_mwe_nxt       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt     = ST_ACCESS;
                    w_grant_nxt     = w_pick;
                    w_last_nxt      = w_pick_idx;
                    w_we_nxt        = w_sel_we;
                    w_oow_nxt       = w_sel_addr[MEM_ARB_RAM_WINDOW_BIT];
                    w_mem_addr_nxt  = w_sel_addr[MEM_ADDR_W-1:0];
                    w_mem_wdata_nxt = w_sel_wdata;
                    w_cs_nxt        = ~w_sel_addr[MEM_ARB_RAM_WINDOW_BIT];
                    w_oe_nxt        = ~w_sel_addr[MEM_ARB_RAM_WINDOW_BIT] & ~w_sel_we;
                    w_mwe_nxt       = ~w_sel_addr[MEM_ARB_RAM_WINDOW_BIT] & w_sel_we;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = ST_DONE;
                w_grant_nxt = '0;
                w_ack_nxt   = r_grant;
                w_err_nxt   = r_oow;
                w_rdata_nxt = (!r_oow && !r_we) ? bus.mem_rdata : '0;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
`ifdef MEM_ARB_LOCK_EN
                // Step last back one slot so the owner is searched first next time
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (r_ack[i] && bus.req_lock[i]) begin
                        w_last_nxt = (r_last == '0) ? IW'(NUM_REQ - 1) : r_last - 1'b1;
                    end
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last      <= IW'(NUM_REQ - 1);
            r_we        <= 1'b0;
            r_oow       <= 1'b0;
            r_grant     <= '0;
            r_ack       <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cs        <= 1'b0;
            r_oe        <= 1'b0;
            r_mwe       <= 1'b0;
        end else begin
            r_last      <= w_last_nxt;
            r_we        <= w_we_nxt;
            r_oow       <= w_oow_nxt;
            r_grant     <= w_grant_nxt;
            r_ack       <= w_ack_nxt;
            r_err       <= w_err_nxt;
            r_rdata     <= w_rdata_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_cs        <= w_cs_nxt;
            r_oe        <= w_oe_nxt;
            r_mwe       <= w_mwe_nxt;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.ack       = r_ack;
    assign bus.err       = r_err;
    assign bus.rdata     = r_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_cs    = r_cs;
    assign bus.mem_oe    = r_oe;
    assign bus.mem_we    = r_mwe;

endmodule

// File: tb/tb_mem_arbiter_m.sv
// Self-checking bench for mem_arbiter_m: directed scenarios followed by
// randomized rounds, all checked against a transaction-level model
// (round-robin start pointer plus a shadow copy of the RAM).
// Lock scenario is built only when MEM_ARB_LOCK_EN is defined.
module tb_mem_arbiter_m;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 8;

    logic clk;
    logic reset;
    logic ram_init;

    mem_arbiter_m_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter_m #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM attached to the arbiter's memory port
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
            ram[8'h12] <= 8'hA5;
        end else if (bus.mem_cs && bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = ram[bus.mem_addr];

    // Reference model state
    logic [7:0] ref_ram [256];
    int         exp_start;   // first requester index the next search looks at
    int         vectors;
    int         miscompares;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One arbitration round, entered and left on a falling edge. Drives the
    // requests, predicts the winner and checks ACCESS, DONE and return to IDLE.
    task automatic run_round(input logic [N-1:0] rq, input logic [N-1:0] we,
                             input logic [N*AW-1:0] addr, input logic [N*DW-1:0] wd,
                             input logic [N-1:0] lk, input bit drop_after,
                             output logic [N-1:0] obs_ack);
        int         w;
        logic [AW-1:0] a;
        bit         oow;
        bit         wr;
        logic [DW-1:0] exp_rd;
        bus.req       = rq;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
`ifdef MEM_ARB_LOCK_EN
        bus.req_lock  = lk;
`endif
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && rq[(exp_start + k) % N]) w = (exp_start + k) % N;
        end
        obs_ack = '0;
        if (w < 0) begin
            @(negedge clk);
            check("idle_grant", bus.grant, 0);
            check("idle_ack", bus.ack, 0);
            return;
        end
        a   = addr[w*AW +: AW];
        oow = a[15];
        wr  = we[w];
        // ACCESS cycle
        @(negedge clk);
        check("acc_grant", bus.grant, 32'(1) << w);
        check("acc_cs", bus.mem_cs, !oow);
        check("acc_oe", bus.mem_oe, !oow && !wr);
        check("acc_we", bus.mem_we, !oow && wr);
        check("acc_ack", bus.ack, 0);
        if (!oow) check("acc_addr", bus.mem_addr, a[7:0]);
        if (!oow && wr) check("acc_wdata", bus.mem_wdata, wd[w*DW +: DW]);
        // DONE cycle
        @(negedge clk);
        exp_rd = (oow || wr) ? 8'h00 : ref_ram[a[7:0]];
        obs_ack = bus.ack;
        check("done_ack", bus.ack, 32'(1) << w);
        check("done_err", bus.err, oow);
        check("done_rdata", bus.rdata, exp_rd);
        check("done_grant", bus.grant, 0);
        check("done_strobes", {bus.mem_cs, bus.mem_oe, bus.mem_we}, 0);
        if (!oow && wr) ref_ram[a[7:0]] = wd[w*DW +: DW];
        exp_start = (w + 1) % N;
`ifdef MEM_ARB_LOCK_EN
        if (lk[w]) exp_start = w;
`endif
        if (drop_after) bus.req = '0;
        // Back in IDLE
        @(negedge clk);
        check("idle_ack_clr", bus.ack, 0);
        check("idle_err_clr", bus.err, 0);
    endtask

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*AW-1:0] addr;
        logic [N*DW-1:0] wd;
        logic [N-1:0]    ack_seen;
        logic [N-1:0]    rq;
        logic [N-1:0]    we;
        logic [N-1:0]    lk;

        vectors     = 0;
        miscompares = 0;
        exp_start   = 0;
        for (int i = 0; i < 256; i++) ref_ram[i] = 8'(i) ^ 8'h5A;
        ref_ram[8'h12] = 8'hA5;

        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
        reset    = 1'b1;
        ram_init = 1'b1;
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        ram_init = 1'b0;

        // Reset values
        check("rst_grant", bus.grant, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_err", bus.err, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_strobes", {bus.mem_cs, bus.mem_oe, bus.mem_we}, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);

        // Contention: both held, grants alternate starting with requester 0
        addr = {16'h0006, 16'h0005};
        for (int k = 0; k < 4; k++) begin
            run_round(2'b11, 2'b00, addr, 16'h0, 2'b00, k == 3, ack_seen);
            check("contention_order", ack_seen, 32'(1) << (k % 2));
        end

        // Single read of RAM[0x12]
        run_round(2'b01, 2'b00, {16'h0000, 16'h0012}, 16'h0, 2'b00, 1'b1, ack_seen);
        check("single_read_data", bus.rdata, 8'hA5);

        // Write then read back by requester 1
        run_round(2'b10, 2'b10, {16'h0040, 16'h0000}, {8'h3C, 8'h00}, 2'b00, 1'b1, ack_seen);
        run_round(2'b10, 2'b00, {16'h0040, 16'h0000}, 16'h0, 2'b00, 1'b1, ack_seen);
        check("readback_ack", ack_seen, 2'b10);

        // Out-of-window read
        run_round(2'b01, 2'b00, {16'h0000, 16'h8001}, 16'h0, 2'b00, 1'b1, ack_seen);
        check("oow_ack", ack_seen, 2'b01);

        // Reset in the middle of ACCESS
        bus.req      = 2'b01;
        bus.req_we   = 2'b00;
        bus.req_addr = {16'h0000, 16'h0012};
        @(negedge clk);
        check("mid_oe_before", bus.mem_oe, 1);
        reset = 1'b1;
        #1;
        check("mid_grant", bus.grant, 0);
        check("mid_strobes", {bus.mem_cs, bus.mem_oe, bus.mem_we}, 0);
        bus.req = '0;
        @(negedge clk);
        check("mid_no_ack", bus.ack, 0);
        reset     = 1'b0;
        exp_start = 0;
        run_round(2'b11, 2'b00, {16'h0021, 16'h0020}, 16'h0, 2'b00, 1'b1, ack_seen);
        check("post_reset_first", ack_seen, 2'b01);

`ifdef MEM_ARB_LOCK_EN
        // Lock keeps requester 0 on top while asserted
        addr = {16'h0031, 16'h0030};
        run_round(2'b11, 2'b00, addr, 16'h0, 2'b01, 1'b0, ack_seen);
        run_round(2'b11, 2'b00, addr, 16'h0, 2'b01, 1'b0, ack_seen);
        check("lock_first", ack_seen, 2'b01);
        run_round(2'b11, 2'b00, addr, 16'h0, 2'b00, 1'b0, ack_seen);
        check("lock_second", ack_seen, 2'b01);
        run_round(2'b11, 2'b00, addr, 16'h0, 2'b00, 1'b1, ack_seen);
        check("lock_release", ack_seen, 2'b10);
`endif

        // Randomized rounds
        for (int r = 0; r < 60; r++) begin
            rq = N'($urandom_range(0, (1 << N) - 1));
            we = N'($urandom);
            lk = N'($urandom);
            for (int i = 0; i < N; i++) begin
                addr[i*AW +: AW] = {($urandom_range(0, 7) == 0), 7'h00, 8'($urandom_range(0, 15))};
                wd[i*DW +: DW]   = 8'($urandom);
            end
            run_round(rq, we, addr, wd, lk, 1'b1, ack_seen);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
